// File: rtl/clk_div_ctrl_pkg.sv
// Shared definitions for the programmable clock divider controller:
// FSM state encoding and the smallest divisor the block accepts.
package clk_div_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,  // stopped, counter parked at 0
        RUN   = 2'd1,  // counting periods, en high
        PEND  = 2'd2,  // divisor update waiting for the period boundary
        DRAIN = 2'd3   // en dropped, finishing the current period
    } state_e;

    localparam int unsigned DIV_MIN = 2;

endpackage

// File: rtl/clk_div_core.sv
// Period counter plus registered clk_div / tick generation.
// Outputs are registered from the next-cycle counter value, so clk_div, tick
// and cnt_last always describe the counter value of the current cycle.
//
// run  : the counter is active in the next cycle (0 parks it at 0)
// load : the next cycle starts a fresh period at cnt=0
// div  : divisor that applies in the next cycle
module clk_div_core
    import clk_div_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             load,
    input  logic [WIDTH-1:0] div,
    output logic             cnt_last,
    output logic             clk_div,
    output logic             tick
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             clk_div_q, clk_div_d;
    logic             tick_q, tick_d;

    // Next counter value and the outputs that belong to it.
    always_comb begin
        cnt_d = '0;
        if (run && !load) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
        clk_div_d = run && (cnt_d >= (div >> 1));
        tick_d    = run && (cnt_d == (div - WIDTH'(1)));
    end

    // Counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            clk_div_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            clk_div_q <= clk_div_d;
            tick_q    <= tick_d;
        end
    end

    // The tick register already flags the last count of a running period.
    assign cnt_last = tick_q;
    assign clk_div  = clk_div_q;
    assign tick     = tick_q;

endmodule

// File: rtl/clk_div_ctrl.sv
// Programmable clock divider controller: run/stop FSM and divisor update
// handshake around the clk_div_core counter.
// Optional feature macro: CLK_DIV_CTRL_PERIOD_CNT_EN adds a 16-bit wrapping
// count of completed periods on output period_cnt.
//
// Handshake: div_req is a level held by the requester until div_ack. A
// request is taken on any clock edge where div_req=1 and busy=0. Divisors
// below DIV_MIN are answered at once with div_ack+div_err. A valid divisor is
// applied at the next period boundary, where the edge that ends a period
// (cnt==div_q-1) and any edge while IDLE both count as boundaries, so the
// new value never produces a runt pulse. div_ack marks the first cycle with
// the new divisor. When the request has to wait, busy covers the wait.
module clk_div_ctrl
    import clk_div_ctrl_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int DIV_RST = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             div_req,
    input  logic [WIDTH-1:0] div_val,
    output logic             div_ack,
    output logic             div_err,
    output logic             busy,
    output logic             clk_div,
    output logic             tick,
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
    output logic [15:0]      period_cnt,
`endif
    output state_e           state_dbg
);

    localparam logic [WIDTH-1:0] DIV_RST_W = WIDTH'(DIV_RST);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] div_pend_q, div_pend_d;
    logic             busy_q, busy_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;

    logic             cnt_last;
    logic             accept, val_ok, at_bnd;
    logic             load_now, defer, load_pend;
    logic             core_run, core_load;

    // Request decode, divisor/handshake next state and FSM transitions.
    always_comb begin
        accept    = div_req && !busy_q;
        val_ok    = div_val >= WIDTH'(DIV_MIN);
        at_bnd    = (state_q == IDLE) || cnt_last;
        load_now  = accept && val_ok && at_bnd;
        defer     = accept && val_ok && !at_bnd;
        load_pend = (state_q == PEND) && cnt_last;

        div_d      = div_q;
        div_pend_d = div_pend_q;
        busy_d     = busy_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;

        if (accept) begin
            div_pend_d = div_val;
        end
        if (accept && !val_ok) begin
            ack_d = 1'b1;
            err_d = 1'b1;
        end
        if (load_now) begin
            div_d = div_val;
            ack_d = 1'b1;
        end
        if (defer) begin
            busy_d = 1'b1;
        end
        if (load_pend) begin
            div_d  = div_pend_q;
            busy_d = 1'b0;
            ack_d  = 1'b1;
        end

        // RUN and DRAIN share transitions; they differ only in what en was.
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (en) state_d = RUN;
            end
            RUN, DRAIN: begin
                if (defer)         state_d = PEND;
                else if (en)       state_d = RUN;
                else if (cnt_last) state_d = IDLE;
                else               state_d = DRAIN;
            end
            PEND: begin
                if (cnt_last) state_d = en ? RUN : IDLE;
            end
            default: state_d = IDLE;
        endcase

        core_run  = (state_d != IDLE);
        core_load = (state_q == IDLE) || cnt_last;
    end

    // FSM, divisor and handshake registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            div_q      <= DIV_RST_W;
            div_pend_q <= '0;
            busy_q     <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            div_pend_q <= div_pend_d;
            busy_q     <= busy_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
        end
    end

    clk_div_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (core_run),
        .load     (core_load),
        .div      (div_d),
        .cnt_last (cnt_last),
        .clk_div  (clk_div),
        .tick     (tick)
    );

`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
    logic [15:0] period_cnt_q;

    // Completed-period counter, wraps naturally at 16'hFFFF.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_cnt_q <= '0;
        end else if (tick) begin
            period_cnt_q <= period_cnt_q + 16'd1;
        end
    end

    assign period_cnt = period_cnt_q;
`endif

    assign div_ack   = ack_q;
    assign div_err   = err_q;
    assign busy      = busy_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl: directed scenarios followed by a
// randomized run, all checked cycle by cycle against a behavioural model of
// the divider (period position, active divisor, pending request).
module tb_clk_div_ctrl;
  import clk_div_ctrl_pkg::*;

  localparam int W      = 8;
  localparam int DIV_R  = 2;

  // ---------------- clock / reset ----------------
  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic en      = 1'b0;
  logic div_req = 1'b0;
  logic [W-1:0] div_val = '0;

  logic   div_ack, div_err, busy, clk_div, tick;
  state_e state_dbg;
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
  logic [15:0] period_cnt;
`endif

  always #5 clk = ~clk;

  clk_div_ctrl #(
    .WIDTH   (W),
    .DIV_RST (DIV_R)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .div_req    (div_req),
    .div_val    (div_val),
    .div_ack    (div_ack),
    .div_err    (div_err),
    .busy       (busy),
    .clk_div    (clk_div),
    .tick       (tick),
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
    .period_cnt (period_cnt),
`endif
    .state_dbg  (state_dbg)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- reference model ----------------
  // m_active: a period is in progress; m_cnt: position within it.
  bit m_active, m_pend, m_en_last, m_ack, m_err;
  int m_cnt, m_div, m_pv, m_pc;

  // scoreboard: expected length of each period, popped on every DUT tick
  logic [W-1:0] exp_q[$];
  int run_len;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active  = 1'b0;
    m_pend    = 1'b0;
    m_en_last = 1'b0;
    m_ack     = 1'b0;
    m_err     = 1'b0;
    m_cnt     = 0;
    m_div     = DIV_R;
    m_pv      = 0;
    m_pc      = 0;
    exp_q.delete();
    run_len   = 0;
  endtask

  function automatic state_e m_state();
    if (!m_active)     return IDLE;
    else if (m_pend)   return PEND;
    else if (m_en_last) return RUN;
    else               return DRAIN;
  endfunction

  // One rising edge of the model, using the inputs the DUT samples.
  task automatic model_step();
    bit boundary, last, acc, pend_n, ack_n, err_n;
    int nd, pv_n;
    if (!rst_n) begin
      model_reset();
      return;
    end
    last     = m_active && (m_cnt == m_div - 1);
    boundary = !m_active || last;
    acc      = div_req && !m_pend;
    nd = m_div; pv_n = m_pv; pend_n = m_pend; ack_n = 0; err_n = 0;
    if (acc && int'(div_val) < 2) begin
      ack_n = 1; err_n = 1;
    end else if (acc && boundary) begin
      nd = int'(div_val); ack_n = 1;
    end else if (acc) begin
      pend_n = 1; pv_n = int'(div_val);
    end
    if (m_pend && last) begin
      nd = m_pv; pend_n = 0; ack_n = 1;
    end
    if (last) m_pc = (m_pc + 1) & 16'hFFFF;
    if (boundary) begin
      m_active = en; m_cnt = 0;
    end else begin
      m_cnt = m_cnt + 1;
    end
    m_div = nd; m_pv = pv_n; m_pend = pend_n;
    m_ack = ack_n; m_err = err_n; m_en_last = en;
  endtask

  task automatic check_outputs();
    bit e_tick;
    logic [W-1:0] plen;
    e_tick = m_active && (m_cnt == m_div - 1);
    chk("clk_div", 32'(clk_div), 32'(m_active && (m_cnt >= m_div / 2)));
    chk("tick",    32'(tick),    32'(e_tick));
    chk("div_ack", 32'(div_ack), 32'(m_ack));
    chk("div_err", 32'(div_err), 32'(m_err));
    chk("busy",    32'(busy),    32'(m_pend));
    chk("state",   32'(state_dbg), 32'(m_state()));
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
    chk("period_cnt", 32'(period_cnt), 32'(m_pc));
`endif
    if (e_tick) exp_q.push_back(W'(m_div));
    if (state_dbg != IDLE) run_len++;
    if (tick === 1'b1) begin
      chk("period_expected", 32'(exp_q.size() > 0), 32'(1));
      if (exp_q.size() > 0) begin
        plen = exp_q.pop_front();
        chk("period_len", 32'(run_len), 32'(plen));
      end
      run_len = 0;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic wait_cnt(input int target);
    int k = 0;
    while (!(m_active && m_cnt == target) && k < 300) begin
      cycle();
      k++;
    end
    chk("wait_cnt", 32'(m_active && m_cnt == target), 32'(1));
  endtask

  task automatic wait_idle();
    int k = 0;
    while (m_active && k < 300) begin
      cycle();
      k++;
    end
    chk("wait_idle", 32'(state_dbg), 32'(IDLE));
  endtask

  // Hold a request until div_ack, dropping it in the ack cycle.
  task automatic do_req(input int val);
    int k = 0;
    div_req = 1'b1;
    div_val = W'(val);
    do begin
      cycle();
      k++;
    end while (div_ack !== 1'b1 && k < 300);
    chk("req_ack", 32'(div_ack), 32'(1));
    div_req = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    rst_n = 1'b0;
    repeat (3) cycle();
    rst_n = 1'b1;
    cycle();

    // divide by the reset divisor
    en = 1'b1;
    repeat (8) cycle();

    // rejected divisor while running
    do_req(1);
    chk("reject_err", 32'(div_err), 32'(1));
    repeat (4) cycle();

    // load in IDLE, then run at 5
    en = 1'b0;
    wait_idle();
    do_req(5);
    chk("idle_load_state", 32'(state_dbg), 32'(IDLE));
    en = 1'b1;
    repeat (15) cycle();

    // divisor 4, then change to 6 mid-period
    do_req(4);
    wait_cnt(1);
    div_req = 1'b1;
    div_val = W'(6);
    cycle();
    chk("pend_busy", 32'(busy), 32'(1));
    do_req(6);
    repeat (14) cycle();

    // drain to idle at div 8, then re-enable inside a drain
    do_req(8);
    wait_cnt(2);
    en = 1'b0;
    wait_idle();
    en = 1'b1;
    wait_cnt(2);
    en = 1'b0;
    wait_cnt(5);
    en = 1'b1;
    repeat (12) cycle();

    // asynchronous reset while an update is pending
    wait_cnt(1);
    div_req = 1'b1;
    div_val = W'(3);
    cycle();
    div_req = 1'b0;
    chk("busy_pre_reset", 32'(busy), 32'(1));
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    cycle();
    cycle();
    rst_n = 1'b1;
    repeat (8) cycle();

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 9) == 0) en = ~en;
      if (!div_req && $urandom_range(0, 7) == 0) begin
        div_req = 1'b1;
        div_val = W'($urandom_range(0, 9));
      end
      cycle();
      if (div_ack === 1'b1 && $urandom_range(0, 5) != 0) div_req = 1'b0;
    end

    div_req = 1'b0;
    en = 1'b0;
    wait_idle();
    repeat (2) cycle();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
